// File: rtl/pcpu_pkg.sv
// Shared constants and state encoding for the pipelined CPU front end.
package pcpu_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_inst_buf.sv
// One-entry capture buffer for an instruction that arrived while decode was stalled.
module if_inst_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic        r_valid;
  logic [31:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request in flight, feeds IF/ID.
// Build option FETCH_BUF_EN adds a capture buffer (HOLD) for responses arriving under stall.
//
//   state | meaning
//   FETCH | issue request at pc (unless redirected)
//   WAIT  | request outstanding; discard marks a response made stale by redirect
//   HOLD  | stalled response held in buffer (FETCH_BUF_EN only)
module if_fetch_stage
  import pcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_p4,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt, w_pc, w_pc_p4, w_redir_pc;
  logic         r_discard, w_discard_nxt;

  // Reset is synchronous, so the PC is muxed to show RESET_PC during the reset cycle itself.
  assign w_pc       = rst ? RESET_PC : r_pc;
  assign w_pc_p4    = w_pc + 32'd4;
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  assign imem_addr = w_pc;
  assign if_pc     = w_pc;
  assign if_pc_p4  = w_pc_p4;

`ifdef FETCH_BUF_EN
  logic        w_buf_load, w_buf_clear, w_buf_valid;
  logic [31:0] w_buf_data;

  if_inst_buf u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (imem_rdata),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data)
  );
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    imem_req      = 1'b0;
    if_valid      = 1'b0;
    if_inst       = NOP_INST;
`ifdef FETCH_BUF_EN
    w_buf_load    = 1'b0;
    w_buf_clear   = 1'b0;
`endif
    if (!rst) begin
      case (r_state)
        FETCH: begin
          if (redirect) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            imem_req    = 1'b1;
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            w_pc_nxt = w_redir_pc;
            if (imem_rvalid) begin
              w_state_nxt   = FETCH;
              w_discard_nxt = 1'b0;
            end else begin
              w_discard_nxt = 1'b1;
            end
          end else if (imem_rvalid) begin
            w_state_nxt = FETCH;
            if (r_discard) begin
              w_discard_nxt = 1'b0;
            end else begin
              if_valid = 1'b1;
              if_inst  = imem_rdata;
              // Without the buffer a stalled response is simply refetched from the same pc.
              if (!stall) w_pc_nxt = w_pc_p4;
`ifdef FETCH_BUF_EN
              else begin
                w_buf_load  = 1'b1;
                w_state_nxt = HOLD;
              end
`endif
            end
          end
        end
`ifdef FETCH_BUF_EN
        HOLD: begin
          if (redirect) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = FETCH;
            w_buf_clear = 1'b1;
          end else begin
            if_valid = w_buf_valid;
            if_inst  = w_buf_data;
            if (!stall) begin
              w_pc_nxt    = w_pc_p4;
              w_state_nxt = FETCH;
              w_buf_clear = 1'b1;
            end
          end
        end
`endif
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random stall/redirect/latency
// against a transaction-level model of fetch ordering and a variable-latency memory.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_req, imem_rvalid, if_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_pc_p4, if_inst;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_pc(if_pc), .if_pc_p4(if_pc_p4), .if_inst(if_inst),
    .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;

  // memory: a single in-flight response slot
  bit          mem_pend = 1'b0;
  int          mem_due  = 0;
  logic [31:0] mem_addr = '0;

  // reference model: expected pc, request in flight, stale-after-redirect, held instruction
  logic [31:0] m_pc    = RST_PC;
  bit          m_out   = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_hold  = 1'b0;
  logic [31:0] m_hbuf  = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_9E17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    bit          rv, resp, e_req, e_val;
    logic [31:0] rd, e_inst, shown;
    rv = mem_pend && (cyc == mem_due);
    rd = rv ? memf(mem_addr) : $urandom;
    if (rv) mem_pend = 1'b0;
    rst = r; stall = s; redirect = d; redirect_pc = t; imem_rvalid = rv; imem_rdata = rd;
    resp = rv && m_out;

    if (r) begin
      shown = RST_PC; e_req = 1'b0; e_val = 1'b0;
    end else if (m_hold) begin
      shown = m_pc; e_req = 1'b0; e_val = !d;
    end else begin
      shown = m_pc; e_req = !m_out && !d; e_val = resp && !m_stale && !d;
    end
    e_inst = !e_val ? NOP : (m_hold ? m_hbuf : rd);

    @(negedge clk);
    chk("imem_req",  {31'b0, imem_req}, {31'b0, e_req});
    chk("imem_addr", imem_addr, shown);
    chk("if_pc",     if_pc, shown);
    chk("if_pc_p4",  if_pc_p4, shown + 32'd4);
    chk("if_valid",  {31'b0, if_valid}, {31'b0, e_val});
    chk("if_inst",   if_inst, e_inst);

    if (imem_req && !r) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_due  = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 4)));
    end

    if (r) begin
      m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (d) begin
        m_pc = {t[31:2], 2'b00}; m_hold = 1'b0;
      end else if (!s) begin
        m_pc = m_pc + 32'd4; m_hold = 1'b0;
      end
    end else begin
      if (d) begin
        m_pc = {t[31:2], 2'b00};
        if (m_out && !rv) m_stale = 1'b1;
        else if (resp) m_stale = 1'b0;
      end else if (resp && m_stale) begin
        m_stale = 1'b0;
      end else if (e_val) begin
        if (!s) m_pc = m_pc + 32'd4;
`ifdef FETCH_BUF_EN
        else begin
          m_hold = 1'b1; m_hbuf = rd;
        end
`endif
      end
      if (resp) m_out = 1'b0;
      if (e_req) m_out = 1'b1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_until_req();
    bit ready;
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!m_out && !m_hold) begin
        ready = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    chk("idle_bound", {31'b0, ready}, 32'd1);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, a);
    idle_until_req();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;

    // reset, then straight-line fetch at latency 1
    lat = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);

    // redirect to an unaligned target while a slow response is in flight
    lat = 3;
    idle_until_req();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    lat = 1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);

    // stall for three cycles while the response for 0x10 arrives
    goto_pc(32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // redirect and stall together with the response
    goto_pc(32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0240);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

    // pc wraps from the top of the address space
    goto_pc(32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // reset during WAIT; the orphaned response lands in the first cycle after release
    lat = 3;
    idle_until_req();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    lat = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // random stall / redirect / latency mix
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(1'b0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
